// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, synchronous flush
// and an optional two-entry skid buffer that makes IN_READY a flop output.
module pipe_stage_reg #(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         CTRL_W    = 3,
    parameter logic [CTRL_W-1:0]   CTRL_IDLE = '0,
    parameter int unsigned         SKID      = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = IN_VALID && in_ready;
    assign out_fire  = valid_q && OUT_READY;

    assign IN_READY  = in_ready;
    assign OUT_VALID = valid_q;
    assign OUT_DATA  = data_q;
    assign OUT_CTRL  = ctrl_q;

    generate
        if (SKID != 0) begin : g_skid
            logic              ready_q;
            logic [DATA_W-1:0] skid_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;

            assign in_ready = ready_q;

            // Main register drives the outputs; skid register absorbs the one entry
            // accepted while the downstream is stalled.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    state_q     <= ST_EMPTY;
                    valid_q     <= 1'b0;
                    data_q      <= '0;
                    ctrl_q      <= CTRL_IDLE;
                    ready_q     <= 1'b1;
                    skid_data_q <= '0;
                    skid_ctrl_q <= CTRL_IDLE;
                end else if (FLUSH) begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ctrl_q  <= CTRL_IDLE;
                    ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_q <= ST_FULL;
                                valid_q <= 1'b1;
                                data_q  <= IN_DATA;
                                ctrl_q  <= IN_CTRL;
                            end
                        end
                        ST_FULL: begin
                            if (in_fire && out_fire) begin
                                data_q <= IN_DATA;
                                ctrl_q <= IN_CTRL;
                            end else if (in_fire) begin
                                state_q     <= ST_SKID;
                                ready_q     <= 1'b0;
                                skid_data_q <= IN_DATA;
                                skid_ctrl_q <= IN_CTRL;
                            end else if (out_fire) begin
                                state_q <= ST_EMPTY;
                                valid_q <= 1'b0;
                                ctrl_q  <= CTRL_IDLE;
                            end
                        end
                        ST_SKID: begin
                            if (out_fire) begin
                                state_q <= ST_FULL;
                                ready_q <= 1'b1;
                                data_q  <= skid_data_q;
                                ctrl_q  <= skid_ctrl_q;
                            end
                        end
                        default: begin
                            state_q <= ST_EMPTY;
                            valid_q <= 1'b0;
                            ctrl_q  <= CTRL_IDLE;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // Accepting while full is only possible when the held entry leaves the same cycle.
            assign in_ready = !valid_q || OUT_READY;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= CTRL_IDLE;
                end else if (FLUSH) begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ctrl_q  <= CTRL_IDLE;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_q <= ST_FULL;
                                valid_q <= 1'b1;
                                data_q  <= IN_DATA;
                                ctrl_q  <= IN_CTRL;
                            end
                        end
                        ST_FULL: begin
                            if (in_fire) begin
                                data_q <= IN_DATA;
                                ctrl_q <= IN_CTRL;
                            end else if (out_fire) begin
                                state_q <= ST_EMPTY;
                                valid_q <= 1'b0;
                                ctrl_q  <= CTRL_IDLE;
                            end
                        end
                        default: begin
                            state_q <= ST_EMPTY;
                            valid_q <= 1'b0;
                            ctrl_q  <= CTRL_IDLE;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule
